axis_sum_acc: RTL and testbench

AXIS_SUM_ACC -- requirements
Module: axis_sum_acc

---
 rtl/axis_sum_acc.sv | 101 ++++++++++
 tb/tb_axis_sum_acc.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sum_acc.sv
// Packet summer: accumulates AXI-Stream beats with saturation at MAXV, presents the
// packet sum on an output stream and holds the last delivered sum for a display.
module axis_sum_acc #(
    parameter int DW   = 8,
    parameter int W    = 16,
    parameter int MAXV = 99
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [W-1:0]  m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_sat,
    output logic [W-1:0]  disp_data
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [W:0]   MAX_EXT = (W+1)'(MAXV);
    localparam logic [W-1:0] MAX_W   = W'(MAXV);

    state_t         state, state_nxt;
    logic [W-1:0]   acc;
    logic           sat_flag;
    logic [W:0]     sum_ext;
    logic           over;
    logic [W-1:0]   sat_sum;
    logic           in_hs;
    logic           out_hs;

    // One extra bit of headroom so acc + s_data can never wrap before the compare.
    assign sum_ext = {1'b0, acc} + (W+1)'(s_data);
    assign over    = sum_ext > MAX_EXT;
    assign sat_sum = over ? MAX_W : sum_ext[W-1:0];

    assign in_hs  = s_valid & s_ready;
    assign out_hs = m_valid & m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples the pre-edge values, independent of statement order.
            state <= state_nxt;
        end
    end

    // Handshake outputs come from the state alone, so no input reaches an output
    // combinationally.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            ACC: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_nxt = HOLD;
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sat_flag  <= 1'b0;
            m_data    <= '0;
            m_sat     <= 1'b0;
            disp_data <= '0;
        end else begin
            if (in_hs) begin
                acc      <= sat_sum;
                sat_flag <= sat_flag | over;
                // m_data/m_sat only load on the last beat, so they hold steady in HOLD.
                if (s_last) begin
                    m_data <= sat_sum;
                    m_sat  <= sat_flag | over;
                end
            end
            if (out_hs) begin
                disp_data <= m_data;
                acc       <= '0;
                sat_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_sum_acc.sv
// Self-checking bench for axis_sum_acc: directed scenarios plus a randomised
// stream, with expected packet results queued on a scoreboard.
module tb_axis_sum_acc;

    localparam int DW   = 8;
    localparam int W    = 16;
    localparam int MAXV = 99;

    typedef struct {
        logic [W-1:0] data;
        logic         sat;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sat;
    logic [W-1:0]  disp_data;

    int   checks;
    int   failures;
    int   n_out;
    bit   rand_rdy;
    bit   rand_gap;
    exp_t sb[$];
    logic [W-1:0] exp_disp;

    axis_sum_acc #(.DW(DW), .W(W), .MAXV(MAXV)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sat     (m_sat),
        .disp_data (disp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output side of the scoreboard: pops one entry per output handshake.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_disp = '0;
            end else begin
                checks++;
                if (disp_data !== exp_disp) begin
                    failures++;
                    $display("FAIL disp_data: got %0d expected %0d at %0t", disp_data, exp_disp, $time);
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output: got %0d with empty scoreboard at %0t", m_data, $time);
                    end else begin
                        e = sb.pop_front();
                        n_out++;
                        if (m_data !== e.data || m_sat !== e.sat) begin
                            failures++;
                            $display("FAIL packet_result: got data=%0d sat=%0b expected data=%0d sat=%0b at %0t",
                                     m_data, m_sat, e.data, e.sat, $time);
                        end
                        exp_disp = e.data;
                    end
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic watchdog();
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic put_beat(input logic [DW-1:0] d, input logic last);
        bit acc;
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        s_last  = 1'($urandom);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL beat_accept: beat %0d not accepted within %0d cycles", d, n);
        end
    endtask

    task automatic send_packet(input int len, input logic [DW-1:0] beats[8]);
        int   sum;
        exp_t e;
        sum   = 0;
        e.sat = 1'b0;
        for (int i = 0; i < len; i++) begin
            sum = sum + int'(beats[i]);
            if (sum > MAXV) begin
                sum   = MAXV;
                e.sat = 1'b1;
            end
        end
        e.data = W'(sum);
        sb.push_back(e);
        for (int i = 0; i < len; i++) begin
            if (rand_gap) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            put_beat(beats[i], (i == len - 1));
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || m_sat !== 1'b0 || disp_data !== '0) begin
            failures++;
            $display("FAIL reset_state: got s_ready=%0b m_valid=%0b m_data=%0d m_sat=%0b disp=%0d expected 1 0 0 0 0",
                     s_ready, m_valid, m_data, m_sat, disp_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] b[8];
        b = '{8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        m_ready = 1'b1;
        send_packet(3, b);
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== W'(12) || m_sat !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency: got m_valid=%0b s_ready=%0b m_data=%0d m_sat=%0b expected 1 0 12 0",
                     m_valid, s_ready, m_data, m_sat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (disp_data !== W'(12) || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_handshake: got disp=%0d s_ready=%0b m_valid=%0b expected 12 1 0",
                     disp_data, s_ready, m_valid);
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] b[8];
        b = '{8'd60, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(2, b);
        b = '{8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(2, b);
        b = '{8'd50, 8'd49, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(2, b);
        b = '{8'd99, 8'd5, 8'd255, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
        send_packet(5, b);
        b = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(3, b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [DW-1:0] b[8];
        b = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(1, b);
        checks++;
        if (m_data !== W'(7)) begin
            failures++;
            $display("FAIL single_beat: got %0d expected 7", m_data);
        end
        b = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(2, b);
        checks++;
        if (m_data !== W'(2)) begin
            failures++;
            $display("FAIL acc_cleared: got %0d expected 2", m_data);
        end
        b = '{8'd150, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(1, b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] b[8];
        m_ready = 1'b0;
        b = '{8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(2, b);
        sb.push_back('{data: W'(5), sat: 1'b0});
        s_valid = 1'b1;
        s_data  = 8'd5;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== W'(30) || m_sat !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable: cycle %0d got m_valid=%0b s_ready=%0b m_data=%0d m_sat=%0b expected 1 0 30 0",
                         i, m_valid, s_ready, m_data, m_sat);
            end
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || disp_data !== W'(30)) begin
            failures++;
            $display("FAIL release: got s_ready=%0b m_valid=%0b disp=%0d expected 1 0 30", s_ready, m_valid, disp_data);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== W'(5)) begin
            failures++;
            $display("FAIL stalled_beat: got m_valid=%0b m_data=%0d expected 1 5", m_valid, m_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midpacket();
        logic [DW-1:0] b[8];
        m_ready = 1'b1;
        put_beat(8'd10, 1'b0);
        put_beat(8'd20, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || m_sat !== 1'b0 || disp_data !== '0) begin
            failures++;
            $display("FAIL reset_midpacket: got s_ready=%0b m_valid=%0b m_data=%0d m_sat=%0b disp=%0d expected 1 0 0 0 0",
                     s_ready, m_valid, m_data, m_sat, disp_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        b = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_packet(1, b);
        checks++;
        if (m_data !== W'(5)) begin
            failures++;
            $display("FAIL after_reset: got %0d expected 5", m_data);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        put_beat(8'd8, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== '0) begin
            failures++;
            $display("FAIL reset_hold: got m_valid=%0b s_ready=%0b m_data=%0d expected 0 1 0", m_valid, s_ready, m_data);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [DW-1:0] b[8];
        int n0;
        int len;
        int wait_n;
        n0       = n_out;
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++)
                b[i] = DW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 40 : 255));
            send_packet(len, b);
        end
        wait_n = 0;
        while (sb.size() != 0 && wait_n < 500) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        m_ready  = 1'b1;
        checks++;
        if (sb.size() != 0 || (n_out - n0) != 1000) begin
            failures++;
            $display("FAIL random_count: got %0d results with %0d pending expected 1000 with 0 pending",
                     n_out - n0, sb.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_out    = 0;
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        exp_disp = '0;
        fork
            monitor();
            ready_driver();
            watchdog();
        join_none
        test_reset();
        test_basic();
        test_saturation();
        test_single();
        test_backpressure();
        test_reset_midpacket();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
